card_dealer: RTL and testbench

Parametrised card dealer for the poker datapath. It replaces the free-running modulo counters with a shared LFSR and a 52-card used-card bitmap, so no card is dealt twice until the deck is reshuffled. It deals a full hand, or redeals only the unheld slots, behind a start/busy/done handshake. It sits between the game-state controller and the hand evaluator/display.

---
 rtl/card_pkg.sv | 34 +++
 rtl/card_lfsr.sv | 23 ++
 rtl/card_dealer.sv | 154 +++++++++++++++
 tb/tb_card_dealer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants, FSM state type and index-to-card decode for the card dealer.
package card_pkg;
  localparam int          RANK_W    = 4;
  localparam int          SUIT_W    = 3;
  localparam int          DECK_SIZE = 52;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_DONE
  } state_e;

  // Suit from range compares so no divider is built; rank is the offset within the suit.
  function automatic logic [RANK_W+SUIT_W-1:0] idx_to_card(input logic [5:0] idx);
    logic [RANK_W-1:0] rank;
    logic [SUIT_W-1:0] suit;
    if (idx < 6'd13) begin
      suit = 3'd1;
      rank = 4'(idx + 6'd1);
    end else if (idx < 6'd26) begin
      suit = 3'd2;
      rank = 4'(idx - 6'd12);
    end else if (idx < 6'd39) begin
      suit = 3'd3;
      rank = 4'(idx - 6'd25);
    end else begin
      suit = 3'd4;
      rank = 4'(idx - 6'd38);
    end
    return {rank, suit};
  endfunction
endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR; steps every cycle regardless of dealer state.
module card_lfsr
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_c,
  output logic [15:0] value
);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;
endmodule

// File: rtl/card_dealer.sv
// Deals HAND_SIZE slots from a 52-card deck tracked by a used-card bitmap, drawing
// one LFSR candidate per cycle; held slots are skipped and keep their cards.
module card_dealer
  import card_pkg::*;
#(
  parameter int          HAND_SIZE = 5,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                        clock,
  input  logic                        reset_c,
  input  logic                        deal_start,
  input  logic [HAND_SIZE-1:0]        hold_mask,
  input  logic                        shuffle_clr,
  output logic                        busy,
  output logic                        done,
  output logic                        deck_empty,
  output logic [5:0]                  remaining,
  output logic [RANK_W*HAND_SIZE-1:0] rank_flat,
  output logic [SUIT_W*HAND_SIZE-1:0] suit_flat
);
  localparam int PTR_W = (HAND_SIZE > 1) ? $clog2(HAND_SIZE) : 1;

  state_e                             state_q, state_d;
  logic [DECK_SIZE-1:0]               used_q, used_d;
  logic [5:0]                         remaining_q, remaining_d;
  logic [HAND_SIZE-1:0]               hold_q, hold_d;
  logic                               deal_pend_q, deal_pend_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic [HAND_SIZE-1:0][RANK_W-1:0]   rank_q, rank_d;
  logic [HAND_SIZE-1:0][SUIT_W-1:0]   suit_q, suit_d;
  logic                               busy_q, busy_d, done_q, done_d, empty_q, empty_d;

  logic [15:0]                lfsr;
  logic                       lfsr_unused;
  logic [5:0]                 idx;
  logic                       accept;
  logic [RANK_W+SUIT_W-1:0]   card;
  logic [HAND_SIZE-1:0]       first_src;
  logic                       all_held;
  logic [PTR_W-1:0]           first_ptr, next_ptr;
  logic                       next_found;

  card_lfsr #(.SEED(SEED)) u_lfsr (
    .clock   (clock),
    .reset_c (reset_c),
    .value   (lfsr)
  );

  assign idx         = lfsr[5:0];
  assign lfsr_unused = ^lfsr[15:6];
  assign accept      = (idx < 6'(DECK_SIZE)) && !used_q[idx];
  assign card        = idx_to_card(idx);

  // Slot search: first unheld slot for a new deal, next unheld slot above the pointer mid-deal.
  assign first_src = (state_q == ST_IDLE) ? hold_mask : hold_q;
  assign all_held  = &first_src;

  always_comb begin
    first_ptr  = '0;
    next_ptr   = '0;
    next_found = 1'b0;
    for (int i = HAND_SIZE - 1; i >= 0; i--) begin
      if (!first_src[i]) first_ptr = PTR_W'(i);
      if (!hold_q[i] && (i > int'(ptr_q))) begin
        next_ptr   = PTR_W'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    used_d      = used_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    deal_pend_d = deal_pend_q;
    ptr_d       = ptr_q;
    rank_d      = rank_q;
    suit_d      = suit_q;
    empty_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (shuffle_clr) begin
          state_d     = ST_CLEAR;
          deal_pend_d = deal_start;
          hold_d      = hold_mask;
        end else if (deal_start) begin
          hold_d  = hold_mask;
          ptr_d   = first_ptr;
          state_d = all_held ? ST_DONE : ST_DRAW;
        end
      end
      ST_CLEAR: begin
        used_d      = '0;
        remaining_d = 6'(DECK_SIZE);
        deal_pend_d = 1'b0;
        ptr_d       = first_ptr;
        state_d     = (deal_pend_q && !all_held) ? ST_DRAW : ST_DONE;
      end
      ST_DRAW: begin
        if (remaining_q == '0) begin
          state_d = ST_DONE;
          empty_d = 1'b1;
        end else if (accept) begin
          rank_d[ptr_q] = card[RANK_W+SUIT_W-1:SUIT_W];
          suit_d[ptr_q] = card[SUIT_W-1:0];
          used_d[idx]   = 1'b1;
          remaining_d   = remaining_q - 6'd1;
          if (next_found) ptr_d = next_ptr;
          else            state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_DRAW);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state_q     <= ST_IDLE;
      used_q      <= '0;
      remaining_q <= 6'(DECK_SIZE);
      hold_q      <= '0;
      deal_pend_q <= 1'b0;
      ptr_q       <= '0;
      rank_q      <= '0;
      suit_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      used_q      <= used_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      deal_pend_q <= deal_pend_d;
      ptr_q       <= ptr_d;
      rank_q      <= rank_d;
      suit_q      <= suit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      empty_q     <= empty_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign deck_empty = empty_q;
  assign remaining  = remaining_q;
  assign rank_flat  = rank_q;
  assign suit_flat  = suit_q;
endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a deck/queue model checked every cycle, plus directed
// deals with hand-computed remaining counts, hold behaviour and exhaustion checks.
module tb_card_dealer;
  localparam int HS = 5;

  logic          clock = 1'b0;
  logic          reset_c = 1'b0;
  logic          deal_start = 1'b0;
  logic          shuffle_clr = 1'b0;
  logic [HS-1:0] hold_mask = '0;
  logic          busy, done, deck_empty;
  logic [5:0]    remaining;
  logic [4*HS-1:0] rank_flat;
  logic [3*HS-1:0] suit_flat;

  card_dealer #(.HAND_SIZE(HS), .SEED(16'hACE1)) dut (
    .clock       (clock),
    .reset_c     (reset_c),
    .deal_start  (deal_start),
    .hold_mask   (hold_mask),
    .shuffle_clr (shuffle_clr),
    .busy        (busy),
    .done        (done),
    .deck_empty  (deck_empty),
    .remaining   (remaining),
    .rank_flat   (rank_flat),
    .suit_flat   (suit_flat)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_print < 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      n_print++;
    end
  endtask

  // ---------------- behavioural model ----------------
  int        m_phase;          // 0 idle, 1 clear, 2 draw, 3 done
  bit [15:0] m_lfsr, m_cur;
  bit        m_used[52];
  int        m_rank[HS];
  int        m_suit[HS];
  int        m_pending[$];
  bit        m_deal_after, m_empty;
  logic [HS-1:0] m_hold;
  int        m_c;

  function automatic bit [15:0] lfsr_step(input bit [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int deck_left();
    int n = 0;
    foreach (m_used[k]) if (!m_used[k]) n++;
    return n;
  endfunction

  task automatic queue_slots();
    m_pending.delete();
    for (int i = 0; i < HS; i++) if (!m_hold[i]) m_pending.push_back(i);
  endtask

  always @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      m_phase = 0;
      m_lfsr = 16'hACE1;
      foreach (m_used[k]) m_used[k] = 1'b0;
      foreach (m_rank[k]) begin m_rank[k] = 0; m_suit[k] = 0; end
      m_pending.delete();
      m_deal_after = 1'b0;
      m_empty = 1'b0;
      m_hold = '0;
    end else begin
      m_cur = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      m_empty = 1'b0;
      case (m_phase)
        0: begin
          if (shuffle_clr) begin
            m_phase = 1;
            m_deal_after = deal_start;
            m_hold = hold_mask;
          end else if (deal_start) begin
            m_hold = hold_mask;
            queue_slots();
            m_phase = (m_pending.size() > 0) ? 2 : 3;
          end
        end
        1: begin
          foreach (m_used[k]) m_used[k] = 1'b0;
          m_pending.delete();
          if (m_deal_after) queue_slots();
          m_phase = (m_pending.size() > 0) ? 2 : 3;
          m_deal_after = 1'b0;
        end
        2: begin
          if (deck_left() == 0) begin
            m_phase = 3;
            m_empty = 1'b1;
            m_pending.delete();
          end else begin
            m_c = int'(m_cur[5:0]);
            if (m_c < 52 && !m_used[m_c]) begin
              m_used[m_c] = 1'b1;
              m_rank[m_pending[0]] = m_c % 13 + 1;
              m_suit[m_pending[0]] = m_c / 13 + 1;
              void'(m_pending.pop_front());
              if (m_pending.size() == 0) m_phase = 3;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [4*HS-1:0] exp_rank;
  logic [3*HS-1:0] exp_suit;

  always @(negedge clock) begin
    for (int i = 0; i < HS; i++) begin
      exp_rank[4*i +: 4] = 4'(m_rank[i]);
      exp_suit[3*i +: 3] = 3'(m_suit[i]);
    end
    check("cyc_busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    check("cyc_done", 32'(done), 32'(m_phase == 3));
    check("cyc_deck_empty", 32'(deck_empty), 32'(m_phase == 3 && m_empty));
    check("cyc_remaining", 32'(remaining), 32'(deck_left()));
    check("cyc_rank", 32'(rank_flat), 32'(exp_rank));
    check("cyc_suit", 32'(suit_flat), 32'(exp_suit));
  end

  // ---------------- directed stimulus ----------------
  logic last_empty;
  int   last_cycles;

  task automatic wait_done();
    bit seen = 1'b0;
    last_cycles = 0;
    for (int k = 0; k < 4000; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        last_empty = deck_empty;
        break;
      end
      last_cycles++;
      @(negedge clock);
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic op(input bit d, input bit s, input logic [HS-1:0] hm);
    @(negedge clock);
    deal_start = d;
    shuffle_clr = s;
    hold_mask = hm;
    @(negedge clock);
    deal_start = 1'b0;
    shuffle_clr = 1'b0;
    wait_done();
    $display("op deal=%0d shuffle=%0d hold=%b cycles=%0d remaining=%0d deck_empty=%0b rank=%h suit=%h",
             d, s, hm, last_cycles, remaining, last_empty, rank_flat, suit_flat);
  endtask

  function automatic int card_at(input int i);
    return (int'(suit_flat[3*i +: 3]) - 1) * 13 + int'(rank_flat[4*i +: 4]) - 1;
  endfunction

  task automatic check_hand(input string tag);
    int dup = 0;
    for (int i = 0; i < HS; i++) begin
      int r = int'(rank_flat[4*i +: 4]);
      int s = int'(suit_flat[3*i +: 3]);
      check({tag, "_rank_range"}, 32'(r >= 1 && r <= 13), 32'd1);
      check({tag, "_suit_range"}, 32'(s >= 1 && s <= 4), 32'd1);
    end
    for (int i = 0; i < HS; i++)
      for (int j = i + 1; j < HS; j++)
        if (card_at(i) == card_at(j)) dup++;
    check({tag, "_distinct"}, 32'(dup), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_deck_empty"}, 32'(deck_empty), 32'd0);
    check({tag, "_remaining"}, 32'(remaining), 32'd52);
    check({tag, "_rank"}, 32'(rank_flat), 32'd0);
    check({tag, "_suit"}, 32'(suit_flat), 32'd0);
  endtask

  int h1[HS];
  int saved[HS];
  int hits, dones;

  initial begin
    check("model_lfsr_step", 32'(lfsr_step(16'hACE1)), 32'h0000E270);
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset_c = 1'b1;
    repeat (20) @(negedge clock);
    check_reset_vals("idle20");

    // full deal from a fresh deck
    op(1'b1, 1'b0, 5'b00000);
    check("deal1_remaining", 32'(remaining), 32'd47);
    check("deal1_empty", 32'(last_empty), 32'd0);
    check("deal1_latency", 32'(last_cycles >= HS), 32'd1);
    check_hand("deal1");
    for (int i = 0; i < HS; i++) h1[i] = card_at(i);

    // redeal holding slots 0 and 2
    op(1'b1, 1'b0, 5'b00101);
    check("redeal_remaining", 32'(remaining), 32'd44);
    check("redeal_slot0", 32'(card_at(0)), 32'(h1[0]));
    check("redeal_slot2", 32'(card_at(2)), 32'(h1[2]));
    hits = 0;
    foreach (h1[k]) begin
      if (card_at(1) == h1[k]) hits++;
      if (card_at(3) == h1[k]) hits++;
      if (card_at(4) == h1[k]) hits++;
    end
    check("redeal_new_cards", 32'(hits), 32'd0);
    check_hand("redeal");

    // full hold: done one cycle after the request, nothing drawn
    op(1'b1, 1'b0, 5'b11111);
    check("hold_all_latency", 32'(last_cycles), 32'd0);
    check("hold_all_remaining", 32'(remaining), 32'd44);

    // shuffle only
    op(1'b0, 1'b1, 5'b00000);
    check("shuffle_remaining", 32'(remaining), 32'd52);
    check("shuffle_empty", 32'(last_empty), 32'd0);

    // ten full deals, then one that runs the deck dry
    for (int n = 1; n <= 10; n++) begin
      op(1'b1, 1'b0, 5'b00000);
      check("ten_deals_remaining", 32'(remaining), 32'(52 - 5 * n));
    end
    for (int i = 0; i < HS; i++) saved[i] = card_at(i);
    op(1'b1, 1'b0, 5'b00000);
    check("exhaust_empty", 32'(last_empty), 32'd1);
    check("exhaust_remaining", 32'(remaining), 32'd0);
    for (int i = 2; i < HS; i++) check("exhaust_slot_kept", 32'(card_at(i)), 32'(saved[i]));
    @(negedge clock);
    check("deck_empty_cleared", 32'(deck_empty), 32'd0);

    // simultaneous deal and shuffle: clear first, then deal from the full deck
    op(1'b1, 1'b1, 5'b00000);
    check("deal_shuffle_remaining", 32'(remaining), 32'd47);
    check("deal_shuffle_empty", 32'(last_empty), 32'd0);
    check_hand("deal_shuffle");

    // requests during busy are ignored and not queued
    @(negedge clock);
    deal_start = 1'b1;
    hold_mask = 5'b00000;
    @(negedge clock);
    deal_start = 1'b0;
    dones = 0;
    for (int k = 0; k < 4000 && dones == 0; k++) begin
      if (done === 1'b1) dones++;
      deal_start = (busy === 1'b1) ? 1'b1 : 1'b0;
      shuffle_clr = (busy === 1'b1 && k == 2) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    deal_start = 1'b0;
    shuffle_clr = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) dones++;
      @(negedge clock);
    end
    $display("busy-ignore deal: dones=%0d remaining=%0d", dones, remaining);
    check("busy_ignore_dones", 32'(dones), 32'd1);
    check("busy_ignore_remaining", 32'(remaining), 32'd42);

    // asynchronous reset in the middle of a deal
    @(negedge clock);
    deal_start = 1'b1;
    @(negedge clock);
    deal_start = 1'b0;
    @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset_c = 1'b0;
    #1 check_reset_vals("mid_reset");
    $display("mid-deal reset applied: remaining=%0d busy=%0b", remaining, busy);
    repeat (2) @(negedge clock);
    reset_c = 1'b1;
    op(1'b1, 1'b0, 5'b00000);
    check("post_reset_remaining", 32'(remaining), 32'd47);
    check_hand("post_reset");

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
